// File: rtl/wb_cmd_master_if.sv
// Wishbone classic bus bundle between the command master and the register interconnect.
// master drives cyc/stb/we/adr/dat_w/sel; slave returns dat_r/ack/err/rty.
interface wb_cmd_master_if #(
    parameter int unsigned ADR_BITS = 11
) ();
    logic                cyc;
    logic                stb;
    logic                we;
    logic [ADR_BITS-1:0] adr;
    logic [31:0]         dat_w;
    logic [3:0]          sel;
    logic [31:0]         dat_r;
    logic                ack;
    logic                err;
    logic                rty;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-access initiator: one command in, one bounded bus cycle, one response out.
// Optional rty reissue with a one-cycle gap is enabled by defining WBM_RETRY_EN.
module wb_cmd_master #(
    parameter int unsigned WB_ADR_BITS    = 11,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_we_i,
    input  logic [WB_ADR_BITS-1:0] cmd_adr_i,
    input  logic [31:0]            cmd_dat_i,
    input  logic [3:0]             cmd_sel_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_dat_o,
    output logic [1:0]             rsp_status_o,
    output logic                   busy_o,
    wb_cmd_master_if.master        wb
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_param
        $error("wb_cmd_master: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
`ifdef WBM_RETRY_EN
        , GAP
`endif
    } state_t;

    typedef enum logic [1:0] {
        ST_ACK = 2'b00,
        ST_ERR = 2'b01,
        ST_TMO = 2'b10,
        ST_RTY = 2'b11
    } status_t;

    state_t                 state_q;
    logic [15:0]            timer_q;
    logic                   cmd_ready_q;
    logic                   cyc_q;
    logic                   stb_q;
    logic                   we_q;
    logic [WB_ADR_BITS-1:0] adr_q;
    logic [31:0]            dat_q;
    logic [3:0]             sel_q;
    logic                   rsp_valid_q;
    logic [31:0]            rsp_dat_q;
    status_t                rsp_status_q;
`ifdef WBM_RETRY_EN
    logic [3:0]             retry_q;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cmd_ready_q  <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_ACK;
`ifdef WBM_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        we_q        <= cmd_we_i;
                        adr_q       <= cmd_adr_i;
                        dat_q       <= cmd_dat_i;
                        sel_q       <= cmd_sel_i;
                        timer_q     <= '0;
`ifdef WBM_RETRY_EN
                        retry_q     <= '0;
`endif
                        state_q     <= BUS;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                BUS: begin
                    // Termination on the same edge as the timeout limit takes precedence.
                    if (wb.err || wb.rty || wb.ack) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        if (wb.err) begin
                            rsp_dat_q    <= '0;
                            rsp_status_q <= ST_ERR;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= RESP;
                        end else if (wb.rty) begin
`ifdef WBM_RETRY_EN
                            if (retry_q < 4'(MAX_RETRY)) begin
                                retry_q <= retry_q + 4'd1;
                                timer_q <= '0;
                                state_q <= GAP;
                            end else begin
                                rsp_dat_q    <= '0;
                                rsp_status_q <= ST_RTY;
                                rsp_valid_q  <= 1'b1;
                                state_q      <= RESP;
                            end
`else
                            rsp_dat_q    <= '0;
                            rsp_status_q <= ST_RTY;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= RESP;
`endif
                        end else begin
                            rsp_dat_q    <= we_q ? 32'h0 : wb.dat_r;
                            rsp_status_q <= ST_ACK;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= RESP;
                        end
                    end else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        cyc_q        <= 1'b0;
                        stb_q        <= 1'b0;
                        rsp_dat_q    <= TIMEOUT_DATA;
                        rsp_status_q <= ST_TMO;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

`ifdef WBM_RETRY_EN
                GAP: begin
                    // Address/data/select/we are still held from the original command.
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    state_q <= BUS;
                end
`endif

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign busy_o       = (state_q != IDLE);

    assign wb.cyc   = cyc_q;
    assign wb.stb   = stb_q;
    assign wb.we    = we_q;
    assign wb.adr   = adr_q;
    assign wb.dat_w = dat_q;
    assign wb.sel   = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboarded bench for wb_cmd_master: directed commands against a scripted Wishbone target.
// Retry expectations follow WBM_RETRY_EN in the same way as the design.
module tb_wb_cmd_master;
    localparam int unsigned AW  = 11;
    localparam int unsigned TMO = 16;

    typedef enum int {K_ACK, K_ERR, K_RTY, K_SIL, K_ERRACK} kind_t;
    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  st;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [31:0]   cmd_dat = '0;
    logic [3:0]    cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_dat;
    logic [1:0]    rsp_status;
    logic          busy;

    wb_cmd_master_if #(.ADR_BITS(AW)) bus ();

    wb_cmd_master #(
        .WB_ADR_BITS   (AW),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY     (3),
        .TIMEOUT_DATA  (32'hFFFF_FFFF)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_status_o(rsp_status),
        .busy_o      (busy),
        .wb          (bus)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    rsp_t        exp_q[$];

    kind_t         plan[8];
    int unsigned   lat = 0;
    logic [31:0]   rdata = '0;
    logic          late_ack = 1'b0;
    int unsigned   age = 0, npulse = 0, pidx = 0, cyc_hi = 0, gaps = 0;
    logic [AW-1:0] cap_adr = '0;
    logic [31:0]   cap_dat = '0;
    logic [3:0]    cap_sel = '0;
    logic          cap_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_plan(input kind_t k0, input kind_t k1, input kind_t k2, input kind_t k3,
                            input int unsigned l);
        plan[0] = k0; plan[1] = k1; plan[2] = k2;
        for (int i = 3; i < 8; i++) plan[i] = k3;
        lat = l;
    endtask

    // Scripted target: terminates the Nth stb pulse with plan[N] after lat wait cycles.
    initial begin
        kind_t k;
        bus.ack = 1'b0; bus.err = 1'b0; bus.rty = 1'b0; bus.dat_r = '0;
        forever begin
            @(negedge clk);
            bus.ack = late_ack; bus.err = 1'b0; bus.rty = 1'b0; bus.dat_r = '0;
            if (bus.cyc && bus.stb) begin
                if (age == 0) begin
                    pidx = npulse;
                    npulse++;
                end
                age++;
                k = plan[(pidx < 8) ? pidx : 7];
                if (k != K_SIL && age == lat + 1) begin
                    cap_adr = bus.adr; cap_dat = bus.dat_w; cap_sel = bus.sel; cap_we = bus.we;
                    case (k)
                        K_ACK:    begin bus.ack = 1'b1; bus.dat_r = rdata; end
                        K_ERR:    bus.err = 1'b1;
                        K_RTY:    bus.rty = 1'b1;
                        K_ERRACK: begin bus.err = 1'b1; bus.ack = 1'b1; bus.dat_r = rdata; end
                        default:  ;
                    endcase
                end
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: counts bus activity and checks every accepted response against the scoreboard.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.cyc) cyc_hi++;
            if (busy && !bus.cyc && !rsp_valid) gaps++;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_dat", rsp_dat, e.dat);
                    chk("rsp_status", 32'(rsp_status), 32'(e.st));
                end
            end
        end
    end

    task automatic run_cmd(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic push,
                           input logic [31:0] edat, input logic [1:0] est);
        int n = 0;
        if (push) exp_q.push_back(rsp_t'{dat: edat, st: est});
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("cmd_ready_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
        // Junk on the command port while busy must not reach the bus.
        cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("done_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("rsp_valid_wait", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned p0, c0, g0;

        set_plan(K_ACK, K_ACK, K_ACK, K_ACK, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(bus.cyc), 32'd0);
        chk("rst_stb", 32'(bus.stb), 32'd0);
        chk("rst_adr", 32'(bus.adr), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_status", 32'(rsp_status), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // 1: write, target acks one cycle after stb
        set_plan(K_ACK, K_ACK, K_ACK, K_ACK, 1);
        p0 = npulse; c0 = cyc_hi;
        run_cmd(1'b1, 11'h00C, 32'h0015_0000, 4'b0100, 1'b1, 32'h0, 2'b00);
        wait_done();
        chk("t1_cyc_cycles", cyc_hi - c0, 32'd2);
        chk("t1_pulses", npulse - p0, 32'd1);
        chk("t1_adr", 32'(cap_adr), 32'h00C);
        chk("t1_dat", cap_dat, 32'h0015_0000);
        chk("t1_sel", 32'(cap_sel), 32'b0100);
        chk("t1_we", 32'(cap_we), 32'd1);

        // 2: read, zero-wait ack, response stalled for 5 cycles
        set_plan(K_ACK, K_ACK, K_ACK, K_ACK, 0);
        rdata = 32'h5355_5246;
        rsp_ready = 1'b0;
        c0 = cyc_hi;
        run_cmd(1'b0, 11'h000, 32'hDEAD_0000, 4'hF, 1'b1, 32'h5355_5246, 2'b00);
        wait_rsp_valid();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t2_hold_dat", rsp_dat, 32'h5355_5246);
            chk("t2_hold_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_done();
        chk("t2_cyc_cycles", cyc_hi - c0, 32'd1);
        chk("t2_we", 32'(cap_we), 32'd0);

        // 3: silent target times out; late ack afterwards is ignored
        set_plan(K_SIL, K_SIL, K_SIL, K_SIL, 0);
        rsp_ready = 1'b0;
        p0 = npulse; c0 = cyc_hi;
        run_cmd(1'b0, 11'h010, 32'h0, 4'hF, 1'b1, 32'hFFFF_FFFF, 2'b10);
        wait_rsp_valid();
        @(posedge clk); #1;
        late_ack = 1'b1;
        @(posedge clk); #1;
        late_ack = 1'b0;
        chk("t3_late_status", 32'(rsp_status), 32'd2);
        chk("t3_late_dat", rsp_dat, 32'hFFFF_FFFF);
        chk("t3_late_cyc", 32'(bus.cyc), 32'd0);
        rsp_ready = 1'b1;
        wait_done();
        chk("t3_cyc_cycles", cyc_hi - c0, 32'(TMO));
        chk("t3_pulses", npulse - p0, 32'd1);

        // 4a: err and ack on the same edge -> err
        set_plan(K_ERRACK, K_ERRACK, K_ERRACK, K_ERRACK, 0);
        rdata = 32'h1234_5678;
        run_cmd(1'b0, 11'h004, 32'h0, 4'hF, 1'b1, 32'h0, 2'b01);
        wait_done();

        // 4b: ack lands on the timeout-limit edge -> ack wins
        set_plan(K_ACK, K_ACK, K_ACK, K_ACK, TMO - 1);
        rdata = 32'hCAFE_F00D;
        c0 = cyc_hi;
        run_cmd(1'b0, 11'h7FC, 32'h0, 4'hF, 1'b1, 32'hCAFE_F00D, 2'b00);
        wait_done();
        chk("t4b_cyc_cycles", cyc_hi - c0, 32'(TMO));

        // 5: retry handling
`ifdef WBM_RETRY_EN
        set_plan(K_RTY, K_RTY, K_ACK, K_ACK, 0);
        rdata = 32'h0BAD_BEEF;
        p0 = npulse; c0 = cyc_hi; g0 = gaps;
        run_cmd(1'b0, 11'h020, 32'h0, 4'h3, 1'b1, 32'h0BAD_BEEF, 2'b00);
        wait_done();
        chk("t5_pulses", npulse - p0, 32'd3);
        chk("t5_cyc_cycles", cyc_hi - c0, 32'd3);
        chk("t5_gaps", gaps - g0, 32'd2);
        chk("t5_reissue_sel", 32'(cap_sel), 32'h3);

        set_plan(K_RTY, K_RTY, K_RTY, K_RTY, 0);
        p0 = npulse; g0 = gaps;
        run_cmd(1'b1, 11'h024, 32'h1111_2222, 4'hF, 1'b1, 32'h0, 2'b11);
        wait_done();
        chk("t5_max_pulses", npulse - p0, 32'd4);
        chk("t5_max_gaps", gaps - g0, 32'd3);
`else
        set_plan(K_RTY, K_RTY, K_RTY, K_RTY, 0);
        p0 = npulse; c0 = cyc_hi;
        run_cmd(1'b0, 11'h020, 32'h0, 4'h3, 1'b1, 32'h0, 2'b11);
        wait_done();
        chk("t5_pulses", npulse - p0, 32'd1);
        chk("t5_cyc_cycles", cyc_hi - c0, 32'd1);
`endif

        // 6: reset in the middle of a bus cycle
        set_plan(K_SIL, K_SIL, K_SIL, K_SIL, 0);
        run_cmd(1'b0, 11'h030, 32'h0, 4'hF, 1'b0, 32'h0, 2'b00);
        repeat (2) @(posedge clk);
        #3;
        chk("t6_cyc_before", 32'(bus.cyc), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_cyc_rst", 32'(bus.cyc), 32'd0);
        chk("t6_stb_rst", 32'(bus.stb), 32'd0);
        chk("t6_rsp_valid_rst", 32'(rsp_valid), 32'd0);
        chk("t6_ready_rst", 32'(cmd_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_plan(K_ACK, K_ACK, K_ACK, K_ACK, 0);
        run_cmd(1'b1, 11'h034, 32'hA5A5_5A5A, 4'b1001, 1'b1, 32'h0, 2'b00);
        wait_done();
        chk("t6_after_dat", cap_dat, 32'hA5A5_5A5A);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
